hpdcache_mem_read_arb: RTL and testbench
========================================

Name: hpdcache_mem_read_arb

Overview:
- Shares one memory read-request/read-response channel between NREQ HPDcache instances, or an HPDcache plus a prefetcher or PTW.
- Requests pass through fair round-robin arbitration and a single-entry registered output stage.
- The source index is appended to the memory ID.
- Responses are routed back by that index.
- Per-source outstanding-transaction counters bound how many misses each source can have in flight.

Parameters:
- NREQ, 2, number of requesters (>=2).
- ADDR_W, 56, memory address width.
- ID_W, 7, requester-side memory ID width.
- META_W, 11, packed request metadata (len[7:0], size[2:0]), passed through unchanged.
- DATA_W, 512, read data width.
- MAX_OUTST, 8, maximum in-flight transactions per source (>=1).
- SRC_W, derived = $clog2(NREQ), source index width; the outbound ID width is ID_W+SRC_W.

Ports:
- clk_i in 1 clock.
- rst_ni in 1 asynchronous active-low reset.
- req_valid_i in NREQ per-source read request valid.
- req_ready_o out NREQ per-source read request ready.
- req_addr_i in NREQ*ADDR_W per-source address.
- req_meta_i in NREQ*META_W per-source metadata.
- req_id_i in NREQ*ID_W per-source ID.
- mem_req_valid_o out 1 memory request valid.
- mem_req_ready_i in 1 memory request ready.
- mem_req_addr_o out ADDR_W address.
- mem_req_meta_o out META_W metadata.
- mem_req_id_o out ID_W+SRC_W {src, id}, with src in the MSBs.
- mem_rsp_valid_i in 1 memory response valid.
- mem_rsp_ready_o out 1 memory response ready.
- mem_rsp_id_i in ID_W+SRC_W response ID.
- mem_rsp_data_i in DATA_W response data.
- mem_rsp_last_i in 1 last flit of the transaction.
- mem_rsp_error_i in 1 error flag.
- rsp_valid_o out NREQ per-source response valid.
- rsp_ready_i in NREQ per-source response ready.
- rsp_id_o out ID_W response ID with src stripped (shared bus).
- rsp_data_o out DATA_W shared response data.
- rsp_last_o out 1 shared last flag.
- rsp_error_o out 1 shared error flag.
- outst_o out NREQ*$clog2(MAX_OUTST+1) per-source in-flight count (debug/perf).

Behaviour:

Reset:
- Output stage empty: mem_req_valid_o=0 and address/meta/id registers are 0.
- RR pointer = 0; all outstanding counters = 0.
- req_ready_o is 0 during reset.

Eligibility:
- Source i is eligible when req_valid_i[i]=1 and outst[i] < MAX_OUTST.

Arbitration:
- Round-robin among eligible sources, starting at pointer ptr.
- Priority order: ptr, ptr+1, ..., wrapping modulo NREQ.
- Purely combinational; no grant lock is needed because the accept takes one cycle.

Accept:
- The stage can load when stage_empty OR (mem_req_valid_o AND mem_req_ready_i).
- When it can load and the winner is w: req_ready_o[w]=1 and all other readies are 0.
- On the edge: stage <= {addr, meta, {w, id}}, mem_req_valid_o <= 1, and ptr <= (w+1) mod NREQ.
- If the stage can load but no source is eligible and the stage drains: mem_req_valid_o <= 0; ptr unchanged.

Latency:
- 1 cycle from request handshake to mem_req_valid_o.
- Full throughput: back-to-back acceptance while mem_req_ready_i=1.

Output stage:
- Holds its contents stable while mem_req_valid_o=1 and mem_req_ready_i=0 (AXI-style valid-stability).

Outstanding counters:
- outst[i]++ on request handshake for source i.
- outst[i]-- on a response handshake with mem_rsp_id_i MSBs == i and mem_rsp_last_i=1.
- If both happen in the same cycle, the count is unchanged.
- The counter never exceeds MAX_OUTST, enforced by the eligibility rule.
- A decrement at 0 is an assertion error; the counter saturates at 0.

Response routing (combinational, zero latency):
- s = mem_rsp_id_i[ID_W+SRC_W-1:ID_W].
- rsp_valid_o[s] = mem_rsp_valid_i; all other rsp_valid_o are 0.
- mem_rsp_ready_o = rsp_ready_i[s].
- rsp_id_o = mem_rsp_id_i[ID_W-1:0]; data/last/error pass through unchanged.
- If s >= NREQ (NREQ not a power of 2): mem_rsp_ready_o=1, the response is dropped, and an assertion fires.

Other rules:
- Request and response paths are independent. A response for a source may arrive the same cycle that source issues a new request.
- Asynchronous reset mid-transfer clears the stage and all counters immediately. The memory side must also be reset; in-flight responses after reset are undefined.
- Assertions:
  - At most one req_ready_o is high.
  - Stage stable under backpressure.
  - No counter overflow or underflow.

Test Plan:
1. Reset then idle: all outputs 0 and outst_o=0. Release reset with no requests -> mem_req_valid_o stays 0.
2. NREQ=2, both sources hold req_valid_i=1 continuously, mem_req_ready_i=1, ids 0x05/0x11 -> grants alternate 0,1,0,1. mem_req_id_o alternates 0x005/0x091. One request is issued per cycle after a 1-cycle latency.
3. Backpressure: mem_req_ready_i=0 for 5 cycles with the stage full (addr 0x1000) -> addr/meta/id stable and all req_ready_o=0. Release -> next request loads the same cycle.
4. MAX_OUTST=2: source 0 issues 2 requests with no responses -> source 0 is blocked and source 1 still granted. Return a response id={0,0x05}, last=1 -> outst[0]=1 and source 0 is eligible again the next cycle.
5. Multi-flit response id={1,0x11}: 4 flits, last only on flit 4, rsp_ready_i[1] toggling -> only rsp_valid_o[1] asserted and rsp_id_o=0x11. outst[1] decrements exactly once, on flit 4.
6. Same-cycle request and response for source 0 with outst[0]=1 -> outst[0] stays 1. Asserting rst_ni=0 mid-burst -> mem_req_valid_o=0 and all counters 0 asynchronously.

Source files
------------

// File: rtl/hpdcache_mem_read_arb.sv
// hpdcache_mem_read_arb
//   Shares one memory read channel between NREQ requesters (HPDcache instances,
//   prefetcher, PTW). Requests are round-robin arbitrated into a single-entry
//   registered output stage. The source index is prepended to the memory ID,
//   and responses are routed back by those ID MSBs. A per-source counter caps
//   the number of in-flight transactions at MAX_OUTST.
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   req_*_i / req_ready_o    per-source read request (addr, meta, id)
//   mem_req_*                outbound request, id = {src, id}
//   mem_rsp_*                inbound response, id MSBs select the source
//   rsp_*                    per-source valid/ready, shared id/data/last/error
//   outst_o                  per-source in-flight count (debug/perf)

// Per-source in-flight counter. A request handshake and a last-flit response
// handshake in the same cycle cancel. The counter saturates at 0.
module hpdcache_mem_read_arb_cnt #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)                       cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CNT_W'(MAX_OUTST));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && !inc_i && cnt_q == '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inc_i && !dec_i && full_o));
endmodule

module hpdcache_mem_read_arb #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 56,
  parameter int ID_W      = 7,
  parameter int META_W    = 11,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8,
  parameter int SRC_W     = $clog2(NREQ),
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NREQ-1:0]                   req_valid_i,
  output logic [NREQ-1:0]                   req_ready_o,
  input  logic [NREQ-1:0][ADDR_W-1:0]       req_addr_i,
  input  logic [NREQ-1:0][META_W-1:0]       req_meta_i,
  input  logic [NREQ-1:0][ID_W-1:0]         req_id_i,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [ADDR_W-1:0]                 mem_req_addr_o,
  output logic [META_W-1:0]                 mem_req_meta_o,
  output logic [ID_W+SRC_W-1:0]             mem_req_id_o,
  input  logic                              mem_rsp_valid_i,
  output logic                              mem_rsp_ready_o,
  input  logic [ID_W+SRC_W-1:0]             mem_rsp_id_i,
  input  logic [DATA_W-1:0]                 mem_rsp_data_i,
  input  logic                              mem_rsp_last_i,
  input  logic                              mem_rsp_error_i,
  output logic [NREQ-1:0]                   rsp_valid_o,
  input  logic [NREQ-1:0]                   rsp_ready_i,
  output logic [ID_W-1:0]                   rsp_id_o,
  output logic [DATA_W-1:0]                 rsp_data_o,
  output logic                              rsp_last_o,
  output logic                              rsp_error_o,
  output logic [NREQ-1:0][CNT_W-1:0]        outst_o
);
  logic [NREQ-1:0]        full, elig;
  logic [SRC_W-1:0]       ptr_q, win, cand;
  logic                   any, can_load;
  logic                   vld_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [META_W-1:0]      meta_q;
  logic [ID_W+SRC_W-1:0]  id_q;
  logic [SRC_W-1:0]       rsp_src;

  assign elig     = req_valid_i & ~full;
  assign can_load = !vld_q || mem_req_ready_i;

  // Scan from the farthest priority back to ptr so the closest eligible
  // source (ptr, ptr+1, ...) is the last writer and wins.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = SRC_W'((int'(ptr_q) + k) % NREQ);
      if (elig[cand]) begin
        win = cand;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && can_load && any) req_ready_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      meta_q <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else if (can_load) begin
      vld_q <= any;
      if (any) begin
        addr_q <= req_addr_i[win];
        meta_q <= req_meta_i[win];
        id_q   <= {win, req_id_i[win]};
        ptr_q  <= (win == SRC_W'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end

  assign mem_req_valid_o = vld_q;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_meta_o  = meta_q;
  assign mem_req_id_o    = id_q;

  // Response routing: an out-of-range source (only possible when NREQ is not
  // a power of two) matches no lane, so ready defaults to 1 and it is dropped.
  assign rsp_src = mem_rsp_id_i[ID_W+SRC_W-1:ID_W];

  always_comb begin
    rsp_valid_o     = '0;
    mem_rsp_ready_o = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (rsp_src == SRC_W'(i)) begin
        rsp_valid_o[i]  = mem_rsp_valid_i;
        mem_rsp_ready_o = rsp_ready_i[i];
      end
  end

  assign rsp_id_o    = mem_rsp_id_i[ID_W-1:0];
  assign rsp_data_o  = mem_rsp_data_i;
  assign rsp_last_o  = mem_rsp_last_i;
  assign rsp_error_o = mem_rsp_error_i;

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    hpdcache_mem_read_arb_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (req_valid_i[i] & req_ready_o[i]),
      .dec_i  (mem_rsp_valid_i & mem_rsp_ready_o & mem_rsp_last_i &
               (rsp_src == SRC_W'(i))),
      .cnt_o  (outst_o[i]),
      .full_o (full[i])
    );
  end

  if ((1 << SRC_W) != NREQ) begin : g_bad_src
    a_src_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(mem_rsp_valid_i && int'(rsp_src) >= NREQ));
  end

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_stage_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vld_q && !mem_req_ready_i) |=> (vld_q && $stable(addr_q) &&
                                     $stable(meta_q) && $stable(id_q)));
endmodule

// File: tb/tb_hpdcache_mem_read_arb.sv
module tb_hpdcache_mem_read_arb;
  localparam int NREQ = 2, ADDR_W = 56, ID_W = 7, META_W = 11, DATA_W = 512;
  localparam int MAXO = 2, SRC_W = 1, CNT_W = 2;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NREQ-1:0]              req_valid_i, req_ready_o;
  logic [NREQ-1:0][ADDR_W-1:0]  req_addr_i;
  logic [NREQ-1:0][META_W-1:0]  req_meta_i;
  logic [NREQ-1:0][ID_W-1:0]    req_id_i;
  logic                         mem_req_valid_o, mem_req_ready_i;
  logic [ADDR_W-1:0]            mem_req_addr_o;
  logic [META_W-1:0]            mem_req_meta_o;
  logic [ID_W+SRC_W-1:0]        mem_req_id_o;
  logic                         mem_rsp_valid_i, mem_rsp_ready_o;
  logic [ID_W+SRC_W-1:0]        mem_rsp_id_i;
  logic [DATA_W-1:0]            mem_rsp_data_i;
  logic                         mem_rsp_last_i, mem_rsp_error_i;
  logic [NREQ-1:0]              rsp_valid_o, rsp_ready_i;
  logic [ID_W-1:0]              rsp_id_o;
  logic [DATA_W-1:0]            rsp_data_o;
  logic                         rsp_last_o, rsp_error_o;
  logic [NREQ-1:0][CNT_W-1:0]   outst_o;

  always #5 clk = ~clk;

  hpdcache_mem_read_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .ID_W(ID_W), .META_W(META_W),
    .DATA_W(DATA_W), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_meta_i(req_meta_i), .req_id_i(req_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_meta_o(mem_req_meta_o),
    .mem_req_id_o(mem_req_id_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_last_i(mem_rsp_last_i), .mem_rsp_error_i(mem_rsp_error_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o), .rsp_error_o(rsp_error_o),
    .outst_o(outst_o));

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [META_W-1:0]     meta;
    logic [ID_W+SRC_W-1:0] id;
  } mreq_t;
  typedef struct packed {
    logic [NREQ-1:0]   vld;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } mrsp_t;

  mreq_t req_q[$];
  mrsp_t rsp_q[$];
  mreq_t e_req;
  mrsp_t e_rsp;
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic [ADDR_W-1:0] a, input logic [META_W-1:0] m,
                          input logic [ID_W+SRC_W-1:0] id);
    mreq_t r;
    r.addr = a; r.meta = m; r.id = id;
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] v, input logic [ID_W-1:0] id,
                          input logic [DATA_W-1:0] d, input logic l, input logic er);
    mrsp_t r;
    r.vld = v; r.id = id; r.data = d; r.last = l; r.err = er;
    rsp_q.push_back(r);
  endtask

  // Scoreboard monitor: pops on every handshake of either channel.
  always @(negedge clk) if (rst_ni === 1'b1) begin
    if (mem_req_valid_o && mem_req_ready_i) begin
      if (req_q.size() == 0) chk("mem_req unexpected", 1, 0);
      else begin
        e_req = req_q.pop_front();
        chk("mem_req_addr", mem_req_addr_o, e_req.addr);
        chk("mem_req_meta", mem_req_meta_o, e_req.meta);
        chk("mem_req_id", mem_req_id_o, e_req.id);
      end
    end
    if (mem_rsp_valid_i && mem_rsp_ready_o) begin
      if (rsp_q.size() == 0) chk("rsp unexpected", 1, 0);
      else begin
        e_rsp = rsp_q.pop_front();
        chk("rsp_valid", rsp_valid_o, e_rsp.vld);
        chk("rsp_id", rsp_id_o, e_rsp.id);
        chk("rsp_data", rsp_data_o, e_rsp.data);
        chk("rsp_last", rsp_last_o, e_rsp.last);
        chk("rsp_error", rsp_error_o, e_rsp.err);
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic zero_in();
    req_valid_i = '0; req_addr_i = '0; req_meta_i = '0; req_id_i = '0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_id_i = '0; mem_rsp_data_i = '0;
    mem_rsp_last_i = 0; mem_rsp_error_i = 0; rsp_ready_i = '0;
  endtask

  task automatic set_src();
    req_addr_i[0] = 56'hA0; req_meta_i[0] = 11'h123; req_id_i[0] = 7'h05;
    req_addr_i[1] = 56'hB0; req_meta_i[1] = 11'h456; req_id_i[1] = 7'h11;
  endtask

  task automatic do_reset();
    cyc();
    rst_ni = 0;
    zero_in();
    @(negedge clk);
    chk("reset outst", outst_o, 0);
    cyc();
    rst_ni = 1;
    req_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic tg;
    int k;
    logic [DATA_W-1:0] dv;
    rst_ni = 0;
    zero_in();

    // 1: reset state, then idle
    repeat (2) @(negedge clk);
    chk("rst mem_req_valid", mem_req_valid_o, 0);
    chk("rst addr", mem_req_addr_o, 0);
    chk("rst meta", mem_req_meta_o, 0);
    chk("rst id", mem_req_id_o, 0);
    chk("rst outst", outst_o, 0);
    req_valid_i = 2'b11;
    #1 chk("rst req_ready", req_ready_o, 0);
    req_valid_i = 2'b00;
    cyc();
    rst_ni = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle mem_req_valid", mem_req_valid_o, 0);
      chk("idle rsp_valid", rsp_valid_o, 0);
    end

    // 2: round-robin alternation, back-to-back, blocked at MAXO each
    cyc();
    set_src();
    mem_req_ready_i = 1;
    req_valid_i = 2'b11;
    push_req(56'hA0, 11'h123, 8'h05); push_req(56'hB0, 11'h456, 8'h91);
    push_req(56'hA0, 11'h123, 8'h05); push_req(56'hB0, 11'h456, 8'h91);
    @(negedge clk);
    chk("t2 first ready", req_ready_o, 2'b01);
    repeat (4) begin cyc(); @(negedge clk); end
    chk("t2 blocked ready", req_ready_o, 2'b00);
    chk("t2 outst", outst_o, {2'd2, 2'd2});
    cyc();
    req_valid_i = 2'b00;
    @(negedge clk);
    chk("t2 drained valid", mem_req_valid_o, 0);
    chk("t2 req queue empty", req_q.size(), 0);

    // 3: backpressure with stage full
    do_reset();
    set_src();
    req_addr_i[0] = 56'h1000;
    req_valid_i = 2'b01;
    push_req(56'h1000, 11'h123, 8'h05);
    @(negedge clk);
    chk("t3 load ready", req_ready_o, 2'b01);
    cyc();
    req_valid_i = 2'b10;
    push_req(56'hB0, 11'h456, 8'h91);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3 hold valid", mem_req_valid_o, 1);
      chk("t3 hold addr", mem_req_addr_o, 56'h1000);
      chk("t3 hold meta", mem_req_meta_o, 11'h123);
      chk("t3 hold id", mem_req_id_o, 8'h05);
      chk("t3 hold ready", req_ready_o, 2'b00);
      cyc();
    end
    mem_req_ready_i = 1;
    @(negedge clk);
    chk("t3 release ready", req_ready_o, 2'b10);
    cyc();
    req_valid_i = 2'b00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t3 drained valid", mem_req_valid_o, 0);
    chk("t3 req queue empty", req_q.size(), 0);

    // 4: MAX_OUTST blocking and release by a response
    do_reset();
    set_src();
    mem_req_ready_i = 1;
    req_valid_i = 2'b01;
    push_req(56'hA0, 11'h123, 8'h05); push_req(56'hA0, 11'h123, 8'h05);
    @(negedge clk);
    chk("t4 ready0 a", req_ready_o, 2'b01);
    cyc();
    @(negedge clk);
    chk("t4 ready0 b", req_ready_o, 2'b01);
    chk("t4 outst0 1", outst_o[0], 1);
    cyc();
    req_valid_i = 2'b11;
    push_req(56'hB0, 11'h456, 8'h91);
    @(negedge clk);
    chk("t4 src1 granted", req_ready_o, 2'b10);
    chk("t4 outst0 2", outst_o[0], 2);
    cyc();
    req_valid_i = 2'b01;
    mem_rsp_valid_i = 1; mem_rsp_id_i = 8'h05; mem_rsp_last_i = 1;
    mem_rsp_data_i = 512'hD0; rsp_ready_i = 2'b01;
    push_rsp(2'b01, 7'h05, 512'hD0, 1, 0);
    @(negedge clk);
    chk("t4 still blocked", req_ready_o, 2'b00);
    chk("t4 mem_rsp_ready", mem_rsp_ready_o, 1);
    cyc();
    mem_rsp_valid_i = 0;
    push_req(56'hA0, 11'h123, 8'h05);
    @(negedge clk);
    chk("t4 outst0 after rsp", outst_o[0], 1);
    chk("t4 eligible again", req_ready_o, 2'b01);
    cyc();
    req_valid_i = 2'b00;
    @(negedge clk);
    chk("t4 outst0 re-issue", outst_o[0], 2);
    cyc();
    @(negedge clk);
    chk("t4 req queue empty", req_q.size(), 0);
    chk("t4 rsp queue empty", rsp_q.size(), 0);

    // 5: multi-flit response to source 1 with toggling ready
    cyc();
    mem_rsp_valid_i = 1; mem_rsp_id_i = 8'h91;
    k = 0; tg = 0;
    for (int c = 0; c < 8; c++) begin
      dv = 512'hF0 + 512'(k);
      mem_rsp_data_i = dv;
      mem_rsp_last_i = (k == 3);
      mem_rsp_error_i = (k == 1);
      rsp_ready_i = {tg, 1'b1};
      if (tg) push_rsp(2'b10, 7'h11, dv, k == 3, k == 1);
      @(negedge clk);
      chk("t5 rsp_valid", rsp_valid_o, 2'b10);
      chk("t5 rsp_id", rsp_id_o, 7'h11);
      chk("t5 mem_rsp_ready", mem_rsp_ready_o, tg);
      chk("t5 outst1 held", outst_o[1], 1);
      if (tg) k++;
      tg = !tg;
      cyc();
    end
    mem_rsp_valid_i = 0; mem_rsp_last_i = 0; mem_rsp_error_i = 0;
    @(negedge clk);
    chk("t5 outst1 after last", outst_o[1], 0);
    chk("t5 rsp queue empty", rsp_q.size(), 0);

    // 6: same-cycle request and response for source 0
    do_reset();
    set_src();
    mem_req_ready_i = 1;
    req_valid_i = 2'b01;
    push_req(56'hA0, 11'h123, 8'h05);
    @(negedge clk);
    cyc();
    push_req(56'hA0, 11'h123, 8'h05);
    mem_rsp_valid_i = 1; mem_rsp_id_i = 8'h05; mem_rsp_last_i = 1;
    mem_rsp_data_i = 512'hE0; rsp_ready_i = 2'b01;
    push_rsp(2'b01, 7'h05, 512'hE0, 1, 0);
    @(negedge clk);
    chk("t6 outst0 before", outst_o[0], 1);
    chk("t6 ready0", req_ready_o, 2'b01);
    cyc();
    req_valid_i = 2'b00; mem_rsp_valid_i = 0;
    @(negedge clk);
    chk("t6 outst0 unchanged", outst_o[0], 1);
    cyc();
    @(negedge clk);
    chk("t6 queues empty", req_q.size() + rsp_q.size(), 0);

    // 6b: asynchronous reset mid-burst
    do_reset();
    set_src();
    mem_req_ready_i = 1;
    req_valid_i = 2'b11;
    push_req(56'hA0, 11'h123, 8'h05); push_req(56'hB0, 11'h456, 8'h91);
    @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    cyc();
    chk("t6b stage full pre-reset", mem_req_valid_o, 1);
    chk("t6b req queue empty", req_q.size(), 0);
    #2 rst_ni = 0;
    #1;
    chk("t6b async valid", mem_req_valid_o, 0);
    chk("t6b async outst", outst_o, 0);
    chk("t6b async ready", req_ready_o, 2'b00);
    chk("t6b async addr", mem_req_addr_o, 0);
    req_valid_i = 2'b00;
    cyc();
    rst_ni = 1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
